mem_access_fsm: RTL and testbench
=================================

// Module: mem_access_fsm
// PURPOSE
//  Sequences MEM-stage loads/stores onto an SRAM-like data bus (req/addr_ok/data_ok handshake).
//  Takes the already byte-laned store data, byte enables and access size from the MEM stage.
//  Stalls the pipeline until the bus transaction completes, then holds the load data for write-back.
//  Issues at most one outstanding transaction and never withdraws a request once it is asserted.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width (byte enables are DATA_W/8 = 4 bits)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  mem_en_i       in   1       MEM stage holds a valid load/store
//  mem_wr_i       in   1       1 = store, 0 = load
//  mem_size_i     in   2       0 = byte, 1 = half, 2 = word
//  mem_wen_i      in   4       store byte enables (load: 0)
//  mem_addr_i     in   ADDR_W  access address
//  mem_wdata_i    in   DATA_W  lane-replicated store data
//  mem_flush_i    in   1       exception/flush: current MEM instruction is cancelled
//  ext_stall_i    in   1       another stall source holds the MEM stage
//  stall_o        out  1       pipeline stall request
//  rdata_o        out  DATA_W  captured load data (raw word, before lane extraction)
//  rdata_valid_o  out  1       rdata_o belongs to the current MEM instruction
//  data_req_o     out  1       bus request
//  data_wr_o      out  1       bus write
//  data_size_o    out  2       bus size
//  data_wstrb_o   out  4       bus byte strobes
//  data_addr_o    out  ADDR_W  bus address
//  data_wdata_o   out  DATA_W  bus write data
//  data_addr_ok_i in   1       address accepted
//  data_data_ok_i in   1       data returned / write done
//  data_rdata_i   in   DATA_W  bus read data
// BEHAVIOUR
//  Reset: state=IDLE, cancel=0, all outputs 0 (incl. data_* registers, rdata_o).
//  States: IDLE, REQ, WAIT, DONE. Transitions take effect at the next clk edge.
//  IDLE: when mem_en_i & ~mem_flush_i: latch wr/size/wen/addr/wdata into bus regs, go REQ;
//        stall_o=1 combinationally this cycle. With mem_flush_i=1, no request, stall_o=0.
//  REQ: data_req_o=1, bus fields constant. addr_ok=0 -> stay. addr_ok=1 -> WAIT.
//        addr_ok & data_ok in the same cycle -> capture read data, go DONE.
//  WAIT: data_req_o=0. On data_ok, capture data_rdata_i into rdata_o (loads only), go DONE.
//  DONE: stall_o=0, rdata_valid_o=1. ~ext_stall_i -> IDLE (the pipeline advances this cycle);
//        ext_stall_i=1 -> stay in DONE, no new request, rdata_o held.
//  stall_o = 1 in REQ and WAIT, in IDLE as above, and 0 in DONE.
//  Flush in REQ/WAIT: set cancel. The transaction still completes on the bus
//  (req held until addr_ok, then wait for data_ok). On completion go IDLE, not DONE;
//  rdata_o is not updated and rdata_valid_o stays 0. cancel clears on entering IDLE.
//  Stores never update rdata_o. rdata_o holds its value until the next load capture.
//  Latency with a zero-wait bus (addr_ok in the first REQ cycle, data_ok next cycle):
//  IDLE->REQ->WAIT->DONE, 3 stall cycles.
//  Back-to-back: after DONE->IDLE, the next instruction may issue its request 1 cycle later.
//  Reset mid-transaction: returns to IDLE next cycle. Bus-side recovery belongs to the bus reset.
// TESTING
//  1 Load 0x2004, addr_ok in 2nd REQ cycle, data_ok 3 cycles later with 0xDEADBEEF
//    -> stall_o=1 throughout, DONE: rdata_o=0xDEADBEEF, rdata_valid_o=1, stall_o=0.
//  2 sw 0x1000 data 0x12345678, wen=1111, addr_ok & data_ok same cycle
//    -> one req cycle, wr=1, size=2, wstrb=1111, REQ->DONE, rdata_o unchanged.
//  3 sb 0x1002, wen=0100, wdata=0xABABABAB, addr_ok low 5 cycles
//    -> data_req_o and all bus fields stable for 5 cycles, size=0.
//  4 Load with mem_flush_i pulsed in WAIT -> data_ok completes, FSM goes to IDLE,
//    rdata_valid_o never 1, rdata_o keeps its old value. Flush in IDLE -> no req at all.
//  5 ext_stall_i=1 for 3 cycles in DONE, mem_en_i=1 -> stay in DONE, no req;
//    ext_stall_i=0 -> IDLE; a second load raises data_req_o 1 cycle later.
//  6 rst=1 during WAIT -> next cycle IDLE, data_req_o=0, stall_o=0, rdata_o=0.

Source files
------------

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - MEM-stage load/store sequencer for an SRAM-like req/addr_ok/data_ok bus
//
// Issues one bus transaction at a time for the load or store held in the MEM stage.
// The pipeline stalls until the transaction completes. Load data is then held for write-back.
// A request stays asserted until the bus accepts the address. The bus fields do not change
// while the request is pending.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   mem_*_i            MEM-stage access: enable, write, size, byte enables, address, store data
//   mem_flush_i        the current MEM instruction is cancelled
//   ext_stall_i        another stall source is holding the MEM stage
//   stall_o            pipeline stall request
//   rdata_o            raw load word captured from the bus
//   rdata_valid_o      rdata_o belongs to the instruction now in MEM
//   data_*_o           bus request side (req, wr, size, wstrb, addr, wdata)
//   data_*_i           bus response side (addr_ok, data_ok, rdata)

module mem_access_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en_i,
    input  logic                mem_wr_i,
    input  logic [1:0]          mem_size_i,
    input  logic [DATA_W/8-1:0] mem_wen_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                mem_flush_i,
    input  logic                ext_stall_i,
    output logic                stall_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rdata_valid_o,
    output logic                data_req_o,
    output logic                data_wr_o,
    output logic [1:0]          data_size_o,
    output logic [DATA_W/8-1:0] data_wstrb_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    input  logic                data_addr_ok_i,
    input  logic                data_data_ok_i,
    input  logic [DATA_W-1:0]   data_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                cancel_q, cancel_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                stall;
    logic                req;
    logic                valid;
    logic                complete;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        req      = 1'b0;
        valid    = 1'b0;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (mem_en_i && !mem_flush_i) begin
                    wr_d    = mem_wr_i;
                    size_d  = mem_size_i;
                    wstrb_d = mem_wen_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    state_d = S_REQ;
                    stall   = 1'b1;
                end
            end
            S_REQ: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem_flush_i) begin
                    cancel_d = 1'b1;
                end
                if (data_addr_ok_i) begin
                    // A zero-latency slave may return data with the address handshake.
                    if (data_data_ok_i) begin
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_flush_i) begin
                    cancel_d = 1'b1;
                end
                if (data_data_ok_i) begin
                    complete = 1'b1;
                end
            end
            S_DONE: begin
                valid = 1'b1;
                if (!ext_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush arriving on the completion cycle cancels just like an earlier one.
        // A cancelled access drains the bus but goes back to IDLE without touching rdata.
        if (complete) begin
            if (cancel_q || mem_flush_i) begin
                state_d  = S_IDLE;
                cancel_d = 1'b0;
            end else begin
                state_d = S_DONE;
                if (!wr_q) begin
                    rdata_d = data_rdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= '0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign stall_o       = stall;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = valid;
    assign data_req_o    = req;
    assign data_wr_o     = wr_q;
    assign data_size_o   = size_q;
    assign data_wstrb_o  = wstrb_q;
    assign data_addr_o   = addr_q;
    assign data_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access_fsm.sv
// tb/tb_mem_access_fsm.sv - testbench for mem_access_fsm
//
// Transaction-level reference: each access is described by its fields and bus delays.
// The expected stall length, request window, bus fields and held load word are computed from these.
// The bench plays the bus slave and scrambles MEM-side inputs after issue.

module tb_mem_access_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_i;
    logic        mem_wr_i;
    logic [1:0]  mem_size_i;
    logic [3:0]  mem_wen_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_flush_i;
    logic        ext_stall_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rdata_model = '0;

    always #5 clk = ~clk;

    mem_access_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_en_i       (mem_en_i),
        .mem_wr_i       (mem_wr_i),
        .mem_size_i     (mem_size_i),
        .mem_wen_i      (mem_wen_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_flush_i    (mem_flush_i),
        .ext_stall_i    (ext_stall_i),
        .stall_o        (stall_o),
        .rdata_o        (rdata_o),
        .rdata_valid_o  (rdata_valid_o),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_mem();
        mem_wr_i    = 1'($urandom);
        mem_size_i  = 2'($urandom);
        mem_wen_i   = 4'($urandom);
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
    endtask

    task automatic bus_quiet();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = $urandom;
    endtask

    // One access: a single IDLE issue cycle, then ad+1 REQ cycles (addr_ok in the last one).
    // Then dd WAIT cycles, with data_ok in the last one. If dd is 0, data_ok arrives with addr_ok.
    // fl is the cycle index (from 1) that pulses mem_flush_i, or -1 for none.
    // ext is the number of DONE cycles that are held by ext_stall_i.
    task automatic access(input bit wr, input logic [1:0] sz, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ad, input int dd, input logic [31:0] rd,
                          input int fl, input int ext);
        int total;
        bit canc;
        total = 2 + ad + dd;
        canc  = 1'b0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            ext_stall_i = 1'b0;
            mem_flush_i = (k == fl);
            bus_quiet();
            if (k == 0) begin
                mem_en_i = 1'b1; mem_wr_i = wr; mem_size_i = sz;
                mem_wen_i = wen; mem_addr_i = addr; mem_wdata_i = wd;
            end else begin
                if (k == fl) canc = 1'b1;
                mem_en_i = !canc;
                scramble_mem();
                if (k <= ad + 1) begin
                    data_addr_ok_i = (k - 1 == ad);
                    data_data_ok_i = (k - 1 == ad) && (dd == 0);
                end else begin
                    data_data_ok_i = (k - 1 - ad == dd);
                end
                if (data_data_ok_i) data_rdata_i = rd;
            end
            #1;
            chk("stall_busy", stall_o, 1);
            chk("req_window", data_req_o, (k >= 1) && (k <= ad + 1));
            chk("valid_busy", rdata_valid_o, 0);
            chk("rdata_hold_busy", rdata_o, rdata_model);
            if (k >= 1) begin
                chk("bus_wr", data_wr_o, wr);
                chk("bus_size", data_size_o, sz);
                chk("bus_wstrb", data_wstrb_o, wen);
                chk("bus_addr", data_addr_o, addr);
                chk("bus_wdata", data_wdata_o, wd);
            end
        end
        if (!canc && !wr) rdata_model = rd;
        if (canc) begin
            @(negedge clk);
            mem_en_i = 1'b0; mem_flush_i = 1'b0; ext_stall_i = 1'b0;
            bus_quiet();
            #1;
            chk("cancel_idle_stall", stall_o, 0);
            chk("cancel_idle_req", data_req_o, 0);
            chk("cancel_idle_valid", rdata_valid_o, 0);
            chk("cancel_rdata", rdata_o, rdata_model);
        end else begin
            for (int e = 0; e <= ext; e++) begin
                @(negedge clk);
                mem_en_i = 1'b1; mem_flush_i = 1'b0; ext_stall_i = (e < ext);
                scramble_mem();
                bus_quiet();
                #1;
                chk("done_stall", stall_o, 0);
                chk("done_valid", rdata_valid_o, 1);
                chk("done_req", data_req_o, 0);
                chk("done_rdata", rdata_o, rdata_model);
            end
        end
    endtask

    task automatic flush_in_idle();
        @(negedge clk);
        mem_en_i = 1'b1; mem_flush_i = 1'b1; ext_stall_i = 1'b0;
        scramble_mem();
        bus_quiet();
        #1;
        chk("idle_flush_stall", stall_o, 0);
        chk("idle_flush_req", data_req_o, 0);
        @(negedge clk);
        mem_en_i = 1'b0; mem_flush_i = 1'b0;
        #1;
        chk("idle_flush_req_next", data_req_o, 0);
        chk("idle_flush_stall_next", stall_o, 0);
        chk("idle_flush_valid", rdata_valid_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        mem_en_i = 1'b0; mem_flush_i = 1'b0; ext_stall_i = 1'b0;
        scramble_mem();
        bus_quiet();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_req", data_req_o, 0);
        chk("rst_valid", rdata_valid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_wdata", data_wdata_o, 0);
        chk("rst_wstrb", data_wstrb_o, 0);
        chk("rst_wr_size", {data_wr_o, data_size_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Load: addr_ok in the 2nd REQ cycle, data_ok 3 cycles later.
        access(1'b0, 2'd2, 4'b0000, 32'h2004, 32'h0, 1, 3, 32'hDEADBEEF, -1, 0);
        // Store word: addr_ok and data_ok in the same cycle.
        access(1'b1, 2'd2, 4'b1111, 32'h1000, 32'h12345678, 0, 0, 32'h55AA55AA, -1, 0);
        // Store byte: addr_ok held low for 5 cycles.
        access(1'b1, 2'd0, 4'b0100, 32'h1002, 32'hABABABAB, 5, 1, 32'h0, -1, 0);
        // Load flushed in its second WAIT cycle.
        access(1'b0, 2'd2, 4'b0000, 32'h3000, 32'h0, 0, 3, 32'hCAFEF00D, 3, 0);
        flush_in_idle();
        // DONE held by ext_stall for 3 cycles, then a second load issued back-to-back.
        access(1'b0, 2'd1, 4'b0000, 32'h4002, 32'h0, 0, 1, 32'h0BADC0DE, -1, 3);
        access(1'b0, 2'd2, 4'b0000, 32'h4008, 32'h0, 0, 1, 32'h11223344, -1, 0);

        // Reset during WAIT.
        @(negedge clk);
        mem_en_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'd2; mem_wen_i = 4'b0;
        mem_addr_i = 32'h5000; bus_quiet();
        @(negedge clk);
        scramble_mem(); data_addr_ok_i = 1'b1;
        @(negedge clk);
        bus_quiet(); mem_en_i = 1'b0;
        #1;
        chk("pre_rst_wait_stall", stall_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdata_model = '0;
        #1;
        chk("midrst_req", data_req_o, 0);
        chk("midrst_stall", stall_o, 0);
        chk("midrst_rdata", rdata_o, 0);
        chk("midrst_valid", rdata_valid_o, 0);

        // Randomized back-to-back traffic.
        for (int n = 0; n < 40; n++) begin
            bit wr;
            logic [1:0] sz;
            logic [3:0] wen;
            logic [31:0] addr;
            int ad, dd, fl, total;
            wr   = 1'($urandom);
            sz   = 2'($urandom_range(0, 2));
            addr = $urandom;
            if (sz == 2'd2) begin
                addr[1:0] = 2'b00; wen = 4'b1111;
            end else if (sz == 2'd1) begin
                addr[0] = 1'b0; wen = addr[1] ? 4'b1100 : 4'b0011;
            end else begin
                wen = 4'b0001 << addr[1:0];
            end
            if (!wr) wen = 4'b0000;
            ad    = $urandom_range(0, 3);
            dd    = $urandom_range(0, 3);
            total = 2 + ad + dd;
            fl    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, total - 1)) : -1;
            access(wr, sz, wen, addr, $urandom, ad, dd, $urandom, fl, $urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) flush_in_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
